operand_entry: RTL and testbench
================================

# operand_entry

Front-end input sequencer that turns raw board switches and two pushbuttons into stable calculator operands. Each push of Enter commits the next field: operand A, then operand B, then the operation code. The block drives the calculator's `i_A`, `i_B` and `i_Calc` from registers and pulses `o_valid` when a full operand set is committed. It is the input end of the calculator datapath, opposite the seven-segment display output.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000. Consecutive stable cycles needed to accept a button level (10 ms at 100 MHz). Must be ≥ 2.
- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `sys_rst_n`  in  1  reset, synchronous, active-low.
- `i_SW`  in  5  operand switches; asynchronous.
- `i_Op`  in  2  operation switches; asynchronous.
- `i_Enter`  in  1  commit pushbutton; asynchronous, bouncy, active-high.
- `i_Clear`  in  1  clear pushbutton; asynchronous, bouncy, active-high.
- `o_A`  out  5  committed operand A.
- `o_B`  out  5  committed operand B.
- `o_Calc`  out  2  committed operation code.
- `o_valid`  out  1  one-cycle pulse when `o_Calc` is committed.
- `o_stage`  out  2  current state encoding, for display prompting.

## Operation
- **Synchronizers.** `i_SW`, `i_Op`, `i_Enter` and `i_Clear` each pass through a 2-FF synchronizer. Field values are latched from the synchronized `i_SW` / `i_Op`.
- **Debounce (per button).**
  - Counter increments while the synchronized level differs from the debounced level, and clears to 0 when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 and the levels still differ, the debounced level flips and the counter clears.
  - Press event = debounced level high and previous debounced level low. It lasts exactly one cycle per accepted press.
  - A release produces no event. Glitches shorter than `DEBOUNCE_CYCLES` produce no event.
- **FSM states** (`o_stage`): `S_A`=00, `S_B`=01, `S_OP`=10, `S_DONE`=11.
  - `S_A` + enter event: `o_A`←sync `i_SW`, go to `S_B`.
  - `S_B` + enter event: `o_B`←sync `i_SW`, go to `S_OP`.
  - `S_OP` + enter event: `o_Calc`←sync `i_Op`, `o_valid`=1 for one cycle, go to `S_DONE`.
  - `S_DONE` + enter event: go to `S_A`. `o_A`, `o_B` and `o_Calc` keep their values until overwritten, so the display keeps showing the last result.
  - Clear event in any state: `o_A`, `o_B` and `o_Calc` go to 0, state goes to `S_A`, `o_valid` stays 0.
  - Enter and clear events in the same cycle: clear wins.
- Operands are unsigned 5-bit values passed through unmodified. The op code is passed through; its meaning belongs to the calculator.

## Timing
- **Reset.** `sys_rst_n` low at a rising edge forces:
  - `o_A`=0, `o_B`=0, `o_Calc`=0, `o_valid`=0, `o_stage`=`S_A`;
  - all synchronizers, debounced levels and counters to 0.
- **Reset mid-sequence.** A reset in any state discards partial entry.
- **Button held through reset release.** This produces one press event `DEBOUNCE_CYCLES`+2 edges after release. This is accepted behaviour.
- **Latency.**
  - With `i_Enter` rising before edge 0, the synchronized level is high after edge 2.
  - The debounced level flips at edge 2+`DEBOUNCE_CYCLES`.
  - Registers and state update at edge 3+`DEBOUNCE_CYCLES`.
  - `o_valid` is high for exactly the cycle following that edge.
- **Registered outputs.** All outputs are registered; there is no combinational path from inputs to outputs.
- **Switch timing.** Switches must be stable for 2 cycles before the commit edge; the value latched is the one present 2 edges earlier.
- **Repeat rate.** Back-to-back presses need a release of at least `DEBOUNCE_CYCLES` cycles in between.

## Structure
- **Shared package** `calc_pkg`:
  - state encodings `S_A`, `S_B`, `S_OP`, `S_DONE`;
  - operand width (5) and op width (2), reused by the calculator and display.
- **Sub-module** `debouncer`: synchronizer, counter, debounced level and press-event output, parameterized by `DEBOUNCE_CYCLES`. Instantiated twice, for Enter and Clear.
- The 2-FF synchronizers for the switches and the FSM live in `operand_entry`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `sys_rst_n`=0 for 3 cycles → all outputs 0, `o_stage`=00.
- **Full sequence:**
  - `i_SW`=5'd19, press Enter → `o_A`=19 at edge 7, `o_stage`=01.
  - `i_SW`=5'd7, press Enter → `o_B`=7, `o_stage`=10.
  - `i_Op`=2'b10, press Enter → `o_Calc`=10, `o_valid` high exactly 1 cycle, `o_stage`=11.
- **Bounce rejection:** `i_Enter` toggles 1/0 every 2 cycles for 20 cycles, then held high → exactly one enter event, one state advance.
- **Clear priority:** in `S_B` with `o_A`=19, assert Enter and Clear together, both held past debounce → `o_A`=0, `o_stage`=00, `o_valid` never high.
- **Wrap:** from `S_DONE` with A=19, B=7, press Enter → `o_stage`=00 with `o_A`=19 and `o_B`=7 retained. Next Enter with `i_SW`=0 → `o_A`=0.
- **Mid-operation reset:** in `S_OP`, pulse `sys_rst_n` low for 1 cycle → reset values on the next cycle. A subsequent full sequence behaves exactly as in the full-sequence scenario.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: field widths and operand-entry stage encodings.
package calc_pkg;

  localparam int unsigned OperandWidth = 5;
  localparam int unsigned OpWidth      = 2;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_DONE = 2'b11
  } stage_e;

endpackage

// File: rtl/debouncer.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and one-cycle press event.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntWidth = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          sync_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                prev_q;

  // Counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/operand_entry.sv
// Operand entry sequencer: Enter commits A, then B, then the op code; Clear restarts entry.
module operand_entry
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [OperandWidth-1:0] i_SW,
  input  logic [OpWidth-1:0]      i_Op,
  input  logic                    i_Enter,
  input  logic                    i_Clear,
  output logic [OperandWidth-1:0] o_A,
  output logic [OperandWidth-1:0] o_B,
  output logic [OpWidth-1:0]      o_Calc,
  output logic                    o_valid,
  output logic [1:0]              o_stage
);

  logic [OperandWidth-1:0] sw_meta_q, sw_sync_q;
  logic [OpWidth-1:0]      op_meta_q, op_sync_q;
  logic                    enter_ev, clear_ev;

  stage_e                  state_q, state_d;
  logic [OperandWidth-1:0] a_q, a_d, b_q, b_d;
  logic [OpWidth-1:0]      calc_q, calc_d;
  logic                    valid_q, valid_d;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_db (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .btn_i  (i_Enter),
    .press_o(enter_ev)
  );

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .btn_i  (i_Clear),
    .press_o(clear_ev)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      op_meta_q <= '0;
      op_sync_q <= '0;
    end else begin
      sw_meta_q <= i_SW;
      sw_sync_q <= sw_meta_q;
      op_meta_q <= i_Op;
      op_sync_q <= op_meta_q;
    end
  end

  // Clear takes priority over a simultaneous Enter.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    calc_d  = calc_q;
    valid_d = 1'b0;
    if (clear_ev) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      calc_d  = '0;
    end else if (enter_ev) begin
      unique case (state_q)
        S_A: begin
          a_d     = sw_sync_q;
          state_d = S_B;
        end
        S_B: begin
          b_d     = sw_sync_q;
          state_d = S_OP;
        end
        S_OP: begin
          calc_d  = op_sync_q;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      calc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      calc_q  <= calc_d;
      valid_q <= valid_d;
    end
  end

  assign o_A     = a_q;
  assign o_B     = b_q;
  assign o_Calc  = calc_q;
  assign o_valid = valid_q;
  assign o_stage = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: directed scenarios followed by random button/switch traffic.
module tb_operand_entry;

  localparam int unsigned D = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [4:0] i_SW = '0;
  logic [1:0] i_Op = '0;
  logic       i_Enter = 1'b0;
  logic       i_Clear = 1'b0;
  logic [4:0] o_A, o_B;
  logic [1:0] o_Calc;
  logic       o_valid;
  logic [1:0] o_stage;

  operand_entry #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .i_SW     (i_SW),
    .i_Op     (i_Op),
    .i_Enter  (i_Enter),
    .i_Clear  (i_Clear),
    .o_A      (o_A),
    .o_B      (o_B),
    .o_Calc   (o_Calc),
    .o_valid  (o_valid),
    .o_stage  (o_stage)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: committed fields and the number of Enter presses taken in this round.
  int m_a = 0, m_b = 0, m_calc = 0, m_stage = 0;
  int exp_valids = 0, seen_valids = 0;
  logic [11:0] exp_q[$];
  logic valid_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_calc = 0; m_stage = 0;
  endtask

  task automatic model_enter(input int sw, input int op);
    if (m_stage == 0) m_a = sw;
    else if (m_stage == 1) m_b = sw;
    else if (m_stage == 2) begin
      m_calc = op;
      exp_q.push_back({5'(m_a), 5'(m_b), 2'(m_calc)});
      exp_valids++;
    end
    m_stage = (m_stage + 1) % 4;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_A"}, int'(o_A), m_a);
    check({tag, "_B"}, int'(o_B), m_b);
    check({tag, "_Calc"}, int'(o_Calc), m_calc);
    check({tag, "_stage"}, int'(o_stage), m_stage);
    check({tag, "_valid_idle"}, int'(o_valid), 0);
  endtask

  // Monitor: every valid pulse must match the oldest predicted commit and last one cycle.
  always @(negedge sys_clk) begin
    if (o_valid === 1'b1) begin
      logic [11:0] e;
      seen_valids++;
      check("valid_single_cycle", int'(valid_prev), 0);
      check("valid_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_A", int'(o_A), int'(e[11:7]));
        check("valid_B", int'(o_B), int'(e[6:2]));
        check("valid_Calc", int'(o_Calc), int'(e[1:0]));
      end
    end
    valid_prev = (o_valid === 1'b1);
  end

  task automatic do_press(input logic en, input logic cl, input logic bounce,
                          input logic [4:0] sw, input logic [1:0] op, input string tag);
    int lat;
    logic [1:0] st0;
    @(negedge sys_clk);
    i_SW = sw;
    i_Op = op;
    repeat (3) @(negedge sys_clk);
    st0 = o_stage;
    if (cl) model_reset();
    else if (en) model_enter(int'(sw), int'(op));
    if (bounce) begin
      for (int i = 0; i < 5; i++) begin
        i_Enter = 1'b1;
        repeat (2) @(negedge sys_clk);
        i_Enter = 1'b0;
        repeat (2) @(negedge sys_clk);
      end
    end
    i_Enter = en;
    i_Clear = cl;
    lat = -1;
    for (int i = 1; i <= int'(D) + 8; i++) begin
      @(posedge sys_clk);
      #1;
      if (lat < 0 && o_stage != st0) lat = i;
    end
    if (en && !cl && !bounce) check({tag, "_latency"}, lat, int'(D) + 3);
    @(negedge sys_clk);
    i_Enter = 1'b0;
    i_Clear = 1'b0;
    repeat (D + 6) @(negedge sys_clk);
    check_state(tag);
  endtask

  task automatic do_glitch(input int k);
    @(negedge sys_clk);
    i_Enter = 1'b1;
    repeat (k) @(negedge sys_clk);
    i_Enter = 1'b0;
    repeat (D + 6) @(negedge sys_clk);
    check_state("glitch");
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    model_reset();
    @(posedge sys_clk);
    #1;
    check_state("reset_pulse");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic full_sequence(input string tag);
    do_press(1'b1, 1'b0, 1'b0, 5'd19, 2'b00, {tag, "_A"});
    do_press(1'b1, 1'b0, 1'b0, 5'd7, 2'b00, {tag, "_B"});
    do_press(1'b1, 1'b0, 1'b0, 5'd7, 2'b10, {tag, "_OP"});
  endtask

  initial begin
    int r;
    // Reset held for three cycles
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_state("reset");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    full_sequence("seq1");
    check("seq1_final_A", int'(o_A), 19);
    check("seq1_final_Calc", int'(o_Calc), 2);

    // Wrap retains fields, next Enter with zero switches overwrites A
    do_press(1'b1, 1'b0, 1'b0, 5'd11, 2'b01, "wrap");
    check("wrap_retains_B", int'(o_B), 7);
    do_press(1'b1, 1'b0, 1'b0, 5'd0, 2'b01, "wrap_a0");

    // Clear priority over simultaneous Enter
    do_press(1'b0, 1'b1, 1'b0, 5'd0, 2'b00, "clear");
    do_press(1'b1, 1'b0, 1'b0, 5'd19, 2'b00, "prio_setup");
    do_press(1'b1, 1'b1, 1'b0, 5'd25, 2'b11, "prio");

    // Bounce: one advance only
    do_press(1'b1, 1'b0, 1'b1, 5'd13, 2'b00, "bounce");

    // Mid-operation reset then a clean sequence
    do_press(1'b0, 1'b1, 1'b0, 5'd0, 2'b00, "clear2");
    do_press(1'b1, 1'b0, 1'b0, 5'd19, 2'b00, "mid_A");
    do_press(1'b1, 1'b0, 1'b0, 5'd7, 2'b00, "mid_B");
    pulse_reset();
    full_sequence("seq2");

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60)
        do_press(1'b1, 1'b0, 1'b0, 5'($urandom), 2'($urandom), "rnd_enter");
      else if (r < 70)
        do_press(1'b1, 1'b0, 1'b1, 5'($urandom), 2'($urandom), "rnd_bounce");
      else if (r < 78)
        do_press(1'b0, 1'b1, 1'b0, 5'($urandom), 2'($urandom), "rnd_clear");
      else if (r < 85)
        do_press(1'b1, 1'b1, 1'b0, 5'($urandom), 2'($urandom), "rnd_both");
      else if (r < 95)
        do_glitch(int'($urandom_range(1, 3)));
      else
        pulse_reset();
    end

    repeat (4) @(negedge sys_clk);
    check("valid_count", seen_valids, exp_valids);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
